dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store unit, port 1 is a DMA/debug master.
- Issues at most one memory access per cycle and drives the memory's MemRead/MemWrite/addr/write_data.
- Captures the memory's combinational read_data into a registered response.
- Port 1 may request fixed-length incrementing word bursts. Bursts are bounded, so the CPU stall is bounded.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 4, width of the burst length field; maximum burst is 2^LEN_WIDTH beats.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 access request; held until p0_gnt.
- p0_we  in  1  1 = write, 0 = read.
- p0_addr  in  ADDR_WIDTH  byte address, word aligned.
- p0_wdata  in  DATA_WIDTH  store data.
- p0_gnt  out  1  access issued to memory this cycle.
- p0_rvalid  out  1  read data valid; pulses one cycle after a granted read.
- p0_rdata  out  DATA_WIDTH  registered read data.
- p1_req  in  1  port 1 burst request; held until p1_gnt.
- p1_we  in  1  burst direction, sampled at grant.
- p1_addr  in  ADDR_WIDTH  burst start byte address, word aligned.
- p1_len  in  LEN_WIDTH  beats minus 1, sampled at grant.
- p1_wdata  in  DATA_WIDTH  store data for the current beat.
- p1_gnt  out  1  burst accepted; first beat issued this cycle.
- p1_beat  out  1  a port 1 beat is issued this cycle.
- p1_rvalid  out  1  read beat data valid, one cycle after each read beat.
- p1_rdata  out  DATA_WIDTH  registered read data.
- p1_done  out  1  pulses one cycle after the last beat.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_wdata  out  DATA_WIDTH  to memory write_data.
- mem_rdata  in  DATA_WIDTH  from memory read_data; combinational, same cycle.
- busy  out  1  high while in BURST.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state = IDLE; rr_last = 1 (port 0 wins the first conflict); beat_cnt = 0; every registered output = 0.
- Reset mid-burst aborts the burst immediately: no p1_done, no further rvalid.
- Memory port signals (mem_read, mem_write, mem_addr, mem_wdata) and p0_gnt / p1_gnt / p1_beat are combinational from state and requests.
  - mem_read and mem_write are never both high.
  - With no access issued, mem_read, mem_write, mem_addr and mem_wdata are all 0.
- FSM states: IDLE and BURST.
- IDLE:
  - Only p0_req set: grant port 0. Drive mem_read = ~p0_we, mem_write = p0_we, mem_addr = p0_addr, mem_wdata = p0_wdata. Set rr_last = 0.
  - Only p1_req set: grant port 1. Issue beat 0 at p1_addr with p1_we and p1_wdata; assert p1_gnt and p1_beat. Set rr_last = 1.
    - If p1_len == 0: stay in IDLE; p1_done pulses next cycle.
    - Else: go to BURST with beat_cnt = p1_len, addr_q = p1_addr + 4, we_q = p1_we.
  - Both set: grant the port not granted last (rr_last), then proceed as above. Round-robin is updated only on IDLE grants.
- BURST:
  - Each cycle issue one beat at addr_q with we_q and p1_wdata; assert p1_beat.
  - addr_q += 4, wrapping modulo 2^ADDR_WIDTH.
  - beat_cnt decrements; the beat issued with beat_cnt == 1 is the last beat. After it, go to IDLE and p1_done pulses next cycle.
  - p0_req is stalled (p0_gnt = 0). p1_req is ignored.
  - On return to IDLE, rr_last = 1, so a pending p0_req wins the next conflict.
  - Worst-case CPU stall: 2^LEN_WIDTH cycles.
- Read response:
  - A read issued in cycle N gives rvalid to the owning port in cycle N+1, with rdata = mem_rdata sampled at the end of cycle N.
  - rdata holds its value until the next read for that port.
  - Writes produce no rvalid.
- Port 1 must present the current beat's p1_wdata whenever p1_beat can assert; the arbiter does not buffer write data.
- Address low two bits pass through unchanged; alignment is the requester's responsibility.
- Requests dropped before grant are legal and have no effect.

Decomposition:
- Package dmem_arb_pkg contains:
  - typedef enum logic {IDLE, BURST} arb_state_t;
  - localparam WORD_BYTES = 4;
  - typedef enum logic {PORT_CPU = 0, PORT_DMA = 1} port_id_t, used for rr_last.
- One sub-module, dmem_rr_pick: a 2-way round-robin pick taking req[1:0] and last, and returning the one-hot grant. It is combinational.
- The FSM, beat counter and response registers stay in dmem_arbiter.

Test Plan:
- p0 reads addr 0x0 with mem[0] = 0x00000001 -> p0_gnt in the same cycle; mem_read = 1 and mem_addr = 0x0 in that cycle; p0_rvalid = 1 with p0_rdata = 0x00000001 next cycle.
- p0 and p1 (len = 0, read 0x4) both request from reset -> p0 is granted first, p1 in the following cycle; then both request again -> p1 wins (alternation).
- p1 write burst at 0x10 with len = 3, wdata 0xA0..0xA3 -> four beats at 0x10, 0x14, 0x18, 0x1C; busy high for 3 cycles; p1_done one cycle after the 4th beat.
  - A p0_req raised during the burst gets p0_gnt only in the cycle after the burst's last beat.
- p1 read burst at 0xFFFFFFF8 with len = 2 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; three p1_rvalid pulses, each one cycle after its beat.
- rst_n asserted during the 3rd beat of a len = 7 burst -> outputs 0 immediately; state IDLE; no p1_done; the next p0_req is granted on the first cycle after release.
- p1 burst with len = 15 and p0_req held throughout -> 16 consecutive p1 beats, then p0_gnt; the stall never exceeds 16 cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data memory arbiter
package dmem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int WORD_BYTES = 4;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_id_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - combinational two-way round-robin pick, one-hot grant
import dmem_arb_pkg::*;

module dmem_rr_pick (
    input  logic [1:0] req,
    input  port_id_t   last,
    output logic [1:0] gnt
);

    // On a conflict the port that did not win last time is favoured.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT_DMA) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter, CPU port plus DMA burst port
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [LEN_WIDTH-1:0]  p1_len,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_beat,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_done,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    arb_state_t            state;
    port_id_t              rr_last;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;

    logic [1:0]            pick;
    logic                  in_idle;
    logic                  p1_we_cur;
    logic [ADDR_WIDTH-1:0] p1_addr_cur;
    logic                  p1_last_beat;

    dmem_rr_pick u_pick (
        .req  ({p1_req, p0_req}),
        .last (rr_last),
        .gnt  (pick)
    );

    assign in_idle = (state == IDLE);
    assign busy    = (state == BURST);

    // Beat 0 comes straight from the request; later beats from the burst registers.
    always_comb begin
        p0_gnt       = in_idle & pick[0];
        p1_gnt       = in_idle & pick[1];
        p1_beat      = p1_gnt | (state == BURST);
        p1_we_cur    = in_idle ? p1_we : we_q;
        p1_addr_cur  = in_idle ? p1_addr : addr_q;
        p1_last_beat = (p1_gnt && (p1_len == '0)) ||
                       ((state == BURST) && (beat_cnt == LEN_WIDTH'(1)));
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (p0_gnt) begin
            mem_read  = ~p0_we;
            mem_write = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_beat) begin
            mem_read  = ~p1_we_cur;
            mem_write = p1_we_cur;
            mem_addr  = p1_addr_cur;
            mem_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_last  <= PORT_DMA;
            beat_cnt <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
        end else if (in_idle) begin
            if (p0_gnt) begin
                rr_last <= PORT_CPU;
            end else if (p1_gnt) begin
                rr_last <= PORT_DMA;
                if (p1_len != '0) begin
                    state    <= BURST;
                    beat_cnt <= p1_len;
                    addr_q   <= p1_addr + ADDR_WIDTH'(WORD_BYTES);
                    we_q     <= p1_we;
                end
            end
        end else begin
            beat_cnt <= beat_cnt - LEN_WIDTH'(1);
            addr_q   <= addr_q + ADDR_WIDTH'(WORD_BYTES);
            if (beat_cnt == LEN_WIDTH'(1)) begin
                state   <= IDLE;
                rr_last <= PORT_DMA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_rdata  <= '0;
            p1_done   <= 1'b0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_beat & ~p1_we_cur;
            p1_done   <= p1_last_beat;
            if (p0_gnt && !p0_we) begin
                p0_rdata <= mem_rdata;
            end
            if (p1_beat && !p1_we_cur) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we;
    logic [31:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_we;
    logic [31:0] p1_addr, p1_wdata;
    logic [3:0]  p1_len;
    logic        p1_gnt, p1_beat, p1_rvalid, p1_done;
    logic [31:0] p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    logic [31:0] mem [0:15];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_len(p1_len),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_beat(p1_beat),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_done(p1_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Small memory model: 16 words, indexed by address bits [5:2].
    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
            mem[0] <= 32'h0000_0001;
        end else if (mem_write) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_len = 0; p1_wdata = 0;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_p0_rvalid", 32'(p0_rvalid), 0);
        check("rst_p1_done", 32'(p1_done), 0);
        check("rst_mem_ctl", {30'd0, mem_read, mem_write}, 0);
        check("rst_mem_addr", mem_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single CPU read
        p0_req = 1; p0_we = 0; p0_addr = 32'h0;
        #1;
        check("t1_gnt", 32'(p0_gnt), 1);
        check("t1_ctl", {30'd0, mem_read, mem_write}, 32'b10);
        check("t1_addr", mem_addr, 32'h0);
        tick();
        p0_req = 0;
        #1;
        check("t1_rvalid", 32'(p0_rvalid), 1);
        check("t1_rdata", p0_rdata, 32'h0000_0001);

        // Conflict from reset, then alternation
        do_reset();
        p0_req = 1; p0_addr = 32'h8;
        p1_req = 1; p1_we = 0; p1_addr = 32'h4; p1_len = 0;
        #1;
        check("t2_c0_gnt", {30'd0, p1_gnt, p0_gnt}, 32'b01);
        tick();
        p0_addr = 32'hC;
        #1;
        check("t2_c1_gnt", {30'd0, p1_gnt, p0_gnt}, 32'b10);
        check("t2_c1_addr", mem_addr, 32'h4);
        check("t2_c1_p0rd", p0_rdata, 32'h1000_0002);
        tick();
        p1_req = 0;
        #1;
        check("t2_c2_gnt", {30'd0, p1_gnt, p0_gnt}, 32'b01);
        check("t2_c2_done", 32'(p1_done), 1);
        check("t2_c2_p1rd", {31'd0, p1_rvalid} ^ 32'(p0_rvalid << 1), 32'h1);
        check("t2_c2_p1rdata", p1_rdata, 32'h1000_0001);
        tick();
        p0_req = 0;
        #1;
        check("t2_c3_p0rv", 32'(p0_rvalid), 1);
        check("t2_c3_p0rd", p0_rdata, 32'h1000_0003);
        check("t2_c3_done", 32'(p1_done), 0);

        // Write burst len 3 at 0x10; CPU raises a read mid-burst
        p1_req = 1; p1_we = 1; p1_addr = 32'h10; p1_len = 3; p1_wdata = 32'hA0;
        #1;
        check("t3_gnt", 32'(p1_gnt), 1);
        check("t3_b0_ctl", {30'd0, mem_read, mem_write}, 32'b01);
        check("t3_b0_addr", mem_addr, 32'h10);
        check("t3_b0_busy", 32'(busy), 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            p1_req = 0; p1_wdata = 32'hA0 + i;
            p0_req = 1; p0_we = 0; p0_addr = 32'h10;
            #1;
            check("t3_beat", 32'(p1_beat), 1);
            check("t3_addr", mem_addr, 32'h10 + 4 * i);
            check("t3_wdata", mem_wdata, 32'hA0 + i);
            check("t3_busy", 32'(busy), 1);
            check("t3_stall", 32'(p0_gnt), 0);
            check("t3_norv", 32'(p1_rvalid), 0);
        end
        tick();
        #1;
        check("t3_done", 32'(p1_done), 1);
        check("t3_busy_end", 32'(busy), 0);
        check("t3_p0_gnt", 32'(p0_gnt), 1);
        check("t3_p0_addr", mem_addr, 32'h10);
        tick();
        p0_req = 0;
        #1;
        check("t3_p0_rv", 32'(p0_rvalid), 1);
        check("t3_p0_rdata", p0_rdata, 32'hA0);
        check("t3_done_off", 32'(p1_done), 0);

        // Read burst wrapping past the top of the address space
        p1_req = 1; p1_we = 0; p1_addr = 32'hFFFF_FFF8; p1_len = 2;
        #1;
        check("t4_gnt", 32'(p1_gnt), 1);
        check("t4_b0_addr", mem_addr, 32'hFFFF_FFF8);
        check("t4_b0_ctl", {30'd0, mem_read, mem_write}, 32'b10);
        tick();
        p1_req = 0;
        #1;
        check("t4_rv0", 32'(p1_rvalid), 1);
        check("t4_rd0", p1_rdata, 32'h1000_000E);
        check("t4_b1_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        #1;
        check("t4_rv1", 32'(p1_rvalid), 1);
        check("t4_rd1", p1_rdata, 32'h1000_000F);
        check("t4_b2_addr", mem_addr, 32'h0);
        check("t4_b2_busy", 32'(busy), 1);
        tick();
        #1;
        check("t4_rv2", 32'(p1_rvalid), 1);
        check("t4_rd2", p1_rdata, 32'h0000_0001);
        check("t4_done", 32'(p1_done), 1);
        check("t4_idle", 32'(busy), 0);
        tick();
        #1;
        check("t4_rv_off", 32'(p1_rvalid), 0);

        // Reset during the third beat of a len 7 read burst
        p1_req = 1; p1_we = 0; p1_addr = 32'h20; p1_len = 7;
        tick();
        p1_req = 0;
        tick();
        #1;
        check("t5_b2_addr", mem_addr, 32'h28);
        rst_n = 0;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_beat", 32'(p1_beat), 0);
        check("t5_rv", 32'(p1_rvalid), 0);
        check("t5_ctl", {30'd0, mem_read, mem_write}, 0);
        check("t5_addr", mem_addr, 0);
        tick();
        check("t5_done_rst", 32'(p1_done), 0);
        rst_n = 1; p0_req = 1; p0_we = 0; p0_addr = 32'h4;
        #1;
        check("t5_p0_gnt", 32'(p0_gnt), 1);
        check("t5_p0_addr", mem_addr, 32'h4);
        tick();
        p0_req = 0;
        #1;
        check("t5_no_done", 32'(p1_done), 0);
        check("t5_no_p1rv", 32'(p1_rvalid), 0);
        check("t5_p0_rd", p0_rdata, 32'h1000_0001);

        // Maximum burst with the CPU waiting throughout
        p1_req = 1; p1_we = 0; p1_addr = 32'h40; p1_len = 15;
        #1;
        check("t6_gnt", 32'(p1_gnt), 1);
        tick();
        p1_req = 0; p0_req = 1; p0_addr = 32'h8;
        for (int i = 1; i < 16; i++) begin
            #1;
            check("t6_beat", 32'(p1_beat), 1);
            check("t6_stall", 32'(p0_gnt), 0);
            check("t6_addr", mem_addr, 32'h40 + 4 * i);
            tick();
        end
        #1;
        check("t6_done", 32'(p1_done), 1);
        check("t6_p0_gnt", 32'(p0_gnt), 1);
        check("t6_p1_beat", 32'(p1_beat), 0);
        tick();
        p0_req = 0;
        #1;
        check("t6_p0_rd", p0_rdata, 32'h1000_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
